// File: rtl/mdio_master_pkg.sv
// Shared definitions for the clause-22 MDIO master: state encoding, frame
// layout constants and helpers that map a slot index to its bit and phase.
package mdio_master_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_HDR,
      S_TA,
      S_DATA,
      S_DONE
   } state_t;

   localparam int PRE_LEN   = 32;
   localparam int HDR_LEN   = 14;
   localparam int TA_LEN    = 2;
   localparam int DATA_LEN  = 16;
   localparam int FRAME_LEN = 64;

   localparam logic [1:0] ST    = 2'b01;
   localparam logic [1:0] OP_RD = 2'b10;
   localparam logic [1:0] OP_WR = 2'b01;
   localparam logic [1:0] TA_WR = 2'b10;

   // Slot indices are zero-based here: index i carries frame slot i+1.
   function automatic state_t slot_state(input logic [5:0] idx);
      if (idx < 6'(PRE_LEN))
         return S_PRE;
      else if (idx < 6'(PRE_LEN + HDR_LEN))
         return S_HDR;
      else if (idx < 6'(PRE_LEN + HDR_LEN + TA_LEN))
         return S_TA;
      return S_DATA;
   endfunction

   function automatic logic frame_bit(input logic [5:0]  idx,
                                      input logic [4:0]  phy,
                                      input logic [4:0]  regad,
                                      input logic        rw,
                                      input logic [15:0] wdata);
      logic [63:0] frame;
      logic [5:0]  pos;
      frame = {32'hFFFF_FFFF, ST, (rw ? OP_WR : OP_RD), phy, regad, TA_WR, wdata};
      pos   = 6'd63 - idx;
      return frame[pos];
   endfunction

   // Reads hand the line to the PHY from the first turnaround slot onward.
   function automatic logic slot_drives(input logic [5:0] idx, input logic rw);
      return rw || (idx < 6'(PRE_LEN + HDR_LEN));
   endfunction

endpackage

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: sequences one 64-slot frame per start request,
// driving MDIO on falling MDC edges and sampling read data on rising edges.
module mdio_master
   import mdio_master_pkg::*;
(
   input  logic        mdc,
   input  logic        rst,
   input  logic [4:0]  phy_addr,
   input  logic [4:0]  reg_addr,
   input  logic [15:0] data_i,
   output logic [15:0] data_o,
   input  logic        start,
   input  logic        rw,
   inout  wire         mdiol,
   output logic        done
);

   state_t      state_reg;
   logic [5:0]  cnt_reg;
   logic [5:0]  cnt_next;
   logic [4:0]  phy_reg;
   logic [4:0]  regad_reg;
   logic        rw_reg;
   logic [15:0] wdata_reg;
   logic [15:0] rdata_reg;
   logic        mdo_reg;
   logic        oe_reg;

   assign cnt_next = cnt_reg + 6'd1;
   assign mdiol    = oe_reg ? mdo_reg : 1'bz;

   always_ff @(negedge mdc or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         phy_reg   <= '0;
         regad_reg <= '0;
         rw_reg    <= 1'b0;
         wdata_reg <= '0;
         mdo_reg   <= 1'b0;
         oe_reg    <= 1'b0;
         done      <= 1'b0;
         data_o    <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start && !done) begin
                  phy_reg   <= phy_addr;
                  regad_reg <= reg_addr;
                  rw_reg    <= rw;
                  wdata_reg <= data_i;
                  cnt_reg   <= '0;
                  mdo_reg   <= frame_bit(6'd0, phy_addr, reg_addr, rw, data_i);
                  oe_reg    <= 1'b1;
                  state_reg <= slot_state(6'd0);
               end
            end
            S_PRE, S_HDR, S_TA, S_DATA: begin
               if (cnt_reg == 6'(FRAME_LEN - 1)) begin
                  mdo_reg   <= 1'b0;
                  oe_reg    <= 1'b0;
                  done      <= 1'b1;
                  state_reg <= S_DONE;
                  if (!rw_reg)
                     data_o <= rdata_reg;
               end else begin
                  cnt_reg   <= cnt_next;
                  mdo_reg   <= frame_bit(cnt_next, phy_reg, regad_reg, rw_reg, wdata_reg);
                  oe_reg    <= slot_drives(cnt_next, rw_reg);
                  state_reg <= slot_state(cnt_next);
               end
            end
            S_DONE: begin
               // done is held until the requester lets go of start.
               if (!start) begin
                  done      <= 1'b0;
                  cnt_reg   <= '0;
                  state_reg <= S_IDLE;
               end
            end
            default: begin
               oe_reg    <= 1'b0;
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   // The DATA phase spans exactly the sixteen rising edges of slots 49..64.
   always_ff @(posedge mdc or posedge rst) begin
      if (rst)
         rdata_reg <= '0;
      else if (state_reg == S_DATA)
         rdata_reg <= {rdata_reg[14:0], mdiol};
   end

endmodule

// File: tb/tb_mdio_master.sv
// Randomized bench for mdio_master: frames expected from the clause-22 layout
// are queued at issue time and compared when done rises.
`timescale 1ns/1ps
module tb_mdio_master;

   logic        mdc = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  phy_addr = '0;
   logic [4:0]  reg_addr = '0;
   logic [15:0] data_i = '0;
   logic        start = 1'b0;
   logic        rw = 1'b0;
   wire  [15:0] data_o;
   wire         done;
   wire         mdio_bus;
   logic        phy_oe = 1'b0;
   logic        phy_val = 1'b0;

   pullup (mdio_bus);
   assign mdio_bus = phy_oe ? phy_val : 1'bz;

   mdio_master dut (
      .mdc      (mdc),
      .rst      (rst),
      .phy_addr (phy_addr),
      .reg_addr (reg_addr),
      .data_i   (data_i),
      .data_o   (data_o),
      .start    (start),
      .rw       (rw),
      .mdiol    (mdio_bus),
      .done     (done)
   );

   always #200 mdc = ~mdc;

   typedef struct packed {
      logic [63:0] frame;
      logic [15:0] data;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] last_rdata = '0;
   logic [63:0] hist = '0;
   logic        done_prev = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Bus history as a PHY would see it: one sample per rising edge.
   always @(posedge mdc) hist <= {hist[62:0], mdio_bus};

   // Monitor: on each done rise, the last 64 samples must be the queued frame.
   always @(negedge mdc) begin
      #1;
      if (done === 1'b1 && done_prev !== 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0 t=%0t", $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("frame", hist, mon_e.frame);
            check("data_o", 64'(data_o), 64'(mon_e.data));
            $display("frame done: bus=%016h data_o=%04h", hist, data_o);
         end
      end
      done_prev = done;
   end

   // The line may only move while MDC is low.
   always @(mdio_bus) begin
      checks++;
      if (mdc === 1'b1) begin
         errors++;
         $display("FAIL bus_edge actual=changed_mdc_high required=stable t=%0t", $time);
      end
   end

   task automatic do_frame(input logic [4:0] phy, input logic [4:0] rg, input logic w,
                           input logic [15:0] wd, input logic [15:0] rd,
                           input int hold, input int drop_at, input int rst_at);
      exp_t e;
      @(posedge mdc);
      #1;
      phy_addr = phy;
      reg_addr = rg;
      rw       = w;
      data_i   = wd;
      start    = 1'b1;
      if (rst_at < 0) begin
         // Reads: turnaround slots are left to the pull-up, then PHY data.
         e.frame = {32'hFFFF_FFFF, 2'b01, (w ? 2'b01 : 2'b10), phy, rg,
                    (w ? {2'b10, wd} : {2'b11, rd})};
         e.data  = w ? last_rdata : rd;
         if (!w) last_rdata = rd;
         exp_q.push_back(e);
      end
      for (int k = 0; k <= 64; k++) begin
         @(negedge mdc);
         #1;
         if (k == 0) begin
            phy_addr = 5'($urandom);
            reg_addr = 5'($urandom);
            data_i   = 16'($urandom);
            rw       = 1'($urandom);
         end
         if (k == rst_at) begin
            rst    = 1'b1;
            start  = 1'b0;
            phy_oe = 1'b0;
            #1;
            check("rst_bus", 64'(mdio_bus), 64'd1);
            check("rst_done", 64'(done), 64'd0);
            check("rst_data_o", 64'(data_o), 64'd0);
            last_rdata = '0;
            #5 rst = 1'b0;
            $display("reset applied in slot %0d", k + 1);
            return;
         end
         if (k == drop_at) start = 1'b0;
         if (!w) begin
            if (k >= 48 && k <= 63) begin
               phy_oe  = 1'b1;
               phy_val = rd[4'(63 - k)];
            end else if (k == 64) begin
               phy_oe = 1'b0;
            end
         end
      end
      check("done_set", 64'(done), 64'd1);
      if (start) begin
         for (int h = 0; h < hold; h++) begin
            @(negedge mdc);
            #1;
            check("done_hold", 64'(done), 64'd1);
            check("bus_idle", 64'(mdio_bus), 64'd1);
         end
         start = 1'b0;
      end
      @(negedge mdc);
      #1;
      check("done_clear", 64'(done), 64'd0);
      $display("txn phy=%02h reg=%02h rw=%0d wd=%04h rd=%04h hold=%0d drop=%0d",
               phy, rg, w, wd, rd, hold, drop_at);
   endtask

   initial begin
      repeat (2) @(negedge mdc);
      #1;
      check("reset_done", 64'(done), 64'd0);
      check("reset_data_o", 64'(data_o), 64'd0);
      check("reset_bus", 64'(mdio_bus), 64'd1);
      rst = 1'b0;

      do_frame(5'd1, 5'h00, 1'b1, 16'h1140, 16'h0000, 0, -1, -1);
      do_frame(5'd1, 5'h11, 1'b0, 16'h0000, 16'hAC02, 0, -1, -1);
      do_frame(5'd3, 5'h02, 1'b1, 16'hBEEF, 16'h0000, 5, -1, -1);
      do_frame(5'd4, 5'h09, 1'b0, 16'h0000, 16'h3C96, 0, 9, -1);

      for (int i = 0; i < 10; i++) begin
         do_frame(5'($urandom), 5'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : -1, -1);
      end

      do_frame(5'd2, 5'h01, 1'b0, 16'h0000, 16'h5A5A, 0, -1, -1);
      do_frame(5'h05, 5'h1F, 1'b1, 16'hFFFF, 16'h0000, 0, -1, 39);
      do_frame(5'h05, 5'h1F, 1'b1, 16'hFFFF, 16'h0000, 0, -1, -1);
      do_frame(5'h06, 5'h0A, 1'b0, 16'h0000, 16'h8001, 1, -1, -1);

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio

Interface
REQ-001 SHALL use these ports: mdc, input, 1, MDIO management clock (period >= 400 ns), also the MDC line to the PHY; the block's single clock.
REQ-002 SHALL use these ports: rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL use these ports: phy_addr, input, 5, PHY address.
REQ-004 SHALL use these ports: reg_addr, input, 5, PHY register address.
REQ-005 SHALL use these ports: data_i, input, 16, write data.
REQ-006 SHALL use these ports: data_o, output, 16, last read data.
REQ-007 SHALL use these ports: start, input, 1, transaction request (level).
REQ-008 SHALL use these ports: rw, input, 1, 0 = read, 1 = write.
REQ-009 SHALL use these ports: mdiol, inout, 1, MDIO data line (open bus, external pull-up).
REQ-010 SHALL use these ports: done, output, 1, transaction complete.
REQ-011 SHALL use one clock, mdc; rst SHALL be asynchronous, active-high.

Function
REQ-012 SHALL implement IEEE 802.3 clause-22 frames of 64 bit slots:
- 32 preamble ones
- ST = 01
- OP = 10 for read, 01 for write
- PHYAD, MSB first
- REGAD, MSB first
- TA, 2 slots
- DATA, 16 bits, MSB first
REQ-013 SHALL change mdiol drive/value only on falling mdc edges and SHALL sample mdiol only on rising mdc edges.
REQ-014 SHALL, in IDLE with start=1 and done=0 at a falling edge F0, latch phy_addr, reg_addr, rw and data_i, and drive slot 1 at F0; slot k is driven at F(k-1).
REQ-015 SHALL ignore input changes after latching, until the next transaction.
REQ-016 SHALL, for a write, drive TA = 1,0 and then data_i[15:0].
REQ-017 SHALL, for a read, release mdiol (high-Z) from the TA slots through slot 64.
REQ-018 SHALL, for a read, sample data bit 15-n on the rising edge inside slot 49+n (n = 0..15).
REQ-019 SHALL, at falling edge F64: release mdiol, set done=1, and for reads load data_o with the 16 sampled bits.
REQ-020 SHALL leave data_o unchanged by write transactions.
REQ-021 SHALL hold done=1 while start=1, and clear done on the first falling edge with start=0.
REQ-022 SHALL start a new frame only after done=0 has been observed together with start=1; back-to-back frames are therefore separated by at least one idle slot.
REQ-023 SHALL complete the frame if start is deasserted mid-frame, then clear done on the next falling edge with start=0.
REQ-024 SHALL keep mdiol high-Z whenever not driving; the drive value SHALL be a 0/1 with a separate output enable.
REQ-025 SHALL use states IDLE → PRE (32) → HDR (14: ST, OP, PHYAD, REGAD) → TA (2) → DATA (16) → DONE → IDLE, with a 6-bit slot counter.

Reset
REQ-026 SHALL, on rst (any time, including mid-frame), immediately apply: state = IDLE, done = 0, data_o = 0, mdiol high-Z, counter = 0, latched fields = 0.
REQ-027 SHALL, after rst release, wait for a new start; no partial frame is resumed.

Structure
REQ-028 SHALL place the following in a shared package: state encoding, frame constants (PRE_LEN = 32, ST = 2'b01, OP_RD = 2'b10, OP_WR = 2'b01, TA_WR = 2'b10, FRAME_LEN = 64).
REQ-029 SHALL be a single module with no sub-modules; the tri-state buffer SHALL be inferred inline.

Verification
REQ-030 SHALL verify write: phy=1, reg=0x00, data_i=0x1140, rw=1, start held → mdiol slots are 32 ones, then 01 01 00001 00000 10 0001000101000000; done=1 after F64; data_o unchanged.
REQ-031 SHALL verify read: phy=1, reg=0x11, rw=0, PHY model drives 0xAC02 in slots 49-64 → master is high-Z from slot 47; data_o = 0xAC02; done=1.
REQ-032 SHALL verify handshake: keep start=1 for 5 cycles after done → done stays 1 and no second frame starts; drop start → done=0 at the next falling edge; raise start → new frame begins.
REQ-033 SHALL verify reset mid-frame: assert rst in slot 40 → mdiol high-Z immediately, done=0, data_o=0; the next start yields a full 64-slot frame.
REQ-034 SHALL verify start dropped at slot 10 → frame completes; done pulses for one cycle and clears at the next falling edge.
REQ-035 SHALL verify edge alignment: the checker samples mdiol on rising edges → every driven slot is stable across its rising edge.
